// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory / port load-store responder:
// default widths, FSM state codes, request classification and the
// sizing rule for the port handshake wait counter.
package mem_io_responder_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_TIMEOUT    = 255;

    // Responder FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_RD,
        ST_PORT_IN,
        ST_PORT_OUT,
        ST_RESP
    } state_e;

    // What a request asks for, decoded from its write/port flags.
    typedef enum logic [1:0] {
        OP_MEM_RD,
        OP_MEM_WR,
        OP_PORT_IN,
        OP_PORT_OUT
    } op_e;

    function automatic op_e decode_op(input logic write, input logic port);
        op_e op;
        if (port) begin
            op = write ? OP_PORT_OUT : OP_PORT_IN;
        end else begin
            op = write ? OP_MEM_WR : OP_MEM_RD;
        end
        return op;
    endfunction

    // The wait counter must hold TIMEOUT-1 and is never narrower than 8 bits.
    function automatic int wait_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout);
        return (w > 8) ? w : 8;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Load/store request bus between the control unit (master) and the
// memory / port responder (slave). One request outstanding at a time;
// the master holds req and its fields until the slave pulses ack.
interface mem_io_responder_if #(
    parameter int DATA_WIDTH = mem_io_responder_pkg::DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_io_responder_pkg::DEFAULT_ADDR_WIDTH
);

    logic                  req;
    logic                  req_write;
    logic                  req_port;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  ack;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, req_write, req_port, req_addr, req_wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, req_write, req_port, req_addr, req_wdata,
        output ack, err, rdata
    );

endinterface

// File: rtl/mem_io_responder_sram.sv
// Single-port synchronous RAM with a registered read port. A write
// also returns the written word on rdata the following cycle.
module mem_sram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write-first access: one read or write per cycle, data out one cycle later.
    // NOTE: the array has no reset on purpose; clearing every word would turn the
    // RAM into a register bank, and nothing depends on its power-up contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Target side of the control unit's load/store bus. Serves RAM loads and
// stores plus port IN/OUT transfers over a valid/ready handshake with a
// bounded wait, and answers every request with a single ack pulse.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_io_responder_if.slave     bus,
    output logic [ADDR_WIDTH-1:0] port_addr,
    output logic [DATA_WIDTH-1:0] port_out_data,
    output logic                  port_out_valid,
    input  logic                  port_out_ready,
    output logic                  port_in_ready,
    input  logic                  port_in_valid,
    input  logic [DATA_WIDTH-1:0] port_in_data
);

    localparam int               CNT_W    = wait_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                state_q;
    state_e                state_d;
    op_e                   op;
    logic                  accept;
    logic                  in_port_wait;
    logic                  wait_expired;
    logic [CNT_W-1:0]      wait_cnt;

    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic                  resp_load;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // A request is taken only while idle; its fields matter on that edge alone.
    assign op           = decode_op(bus.req_write, bus.req_port);
    assign accept       = (state_q == ST_IDLE) && bus.req;
    assign in_port_wait = (state_q == ST_PORT_IN) || (state_q == ST_PORT_OUT);
    assign wait_expired = (wait_cnt == CNT_LAST);

    // Stores commit on the accept edge itself; a reset on that edge blocks them.
    assign ram_we = accept && (op == OP_MEM_WR) && !reset;

    // The RAM address follows the bus directly so a load is issued on the accept
    // edge; the value it reads later, while the bus is ignored, is never used.
    mem_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (bus.req_addr),
        .wdata (bus.req_wdata),
        .rdata (ram_rdata)
    );

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, plus the response to capture when moving into RESP.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        resp_load = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    unique case (op)
                        OP_MEM_WR: begin
                            state_d   = ST_RESP;
                            resp_load = 1'b1;
                        end
                        OP_MEM_RD:   state_d = ST_MEM_RD;
                        OP_PORT_IN:  state_d = ST_PORT_IN;
                        OP_PORT_OUT: state_d = ST_PORT_OUT;
                        default:     state_d = ST_IDLE;
                    endcase
                end
            end
            ST_MEM_RD: begin
                state_d   = ST_RESP;
                resp_load = 1'b1;
                resp_data = ram_rdata;
            end
            ST_PORT_IN: begin
                // A handshake on the expiry cycle still counts as success.
                if (port_in_valid) begin
                    state_d   = ST_RESP;
                    resp_load = 1'b1;
                    resp_data = port_in_data;
                end else if (wait_expired) begin
                    state_d   = ST_RESP;
                    resp_load = 1'b1;
                    resp_err  = 1'b1;
                end
            end
            ST_PORT_OUT: begin
                if (port_out_ready) begin
                    state_d   = ST_RESP;
                    resp_load = 1'b1;
                end else if (wait_expired) begin
                    state_d   = ST_RESP;
                    resp_load = 1'b1;
                    resp_err  = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake wait counter: zero outside the port states, so it starts at 0
    // on the first waiting cycle and counts each cycle spent there.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (in_port_wait) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Latch the port number and OUT word at acceptance; the bus may change after.
    always_ff @(posedge clk) begin
        if (reset) begin
            port_addr     <= '0;
            port_out_data <= '0;
        end else if (accept && bus.req_port) begin
            port_addr <= bus.req_addr;
            if (bus.req_write) begin
                port_out_data <= bus.req_wdata;
            end
        end
    end

    // Response registers: loaded on entry to RESP; err is cleared once ack ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (resp_load) begin
            err_q   <= resp_err;
            rdata_q <= resp_data;
        end else if (state_q == ST_RESP) begin
            err_q   <= 1'b0;
        end
    end

    // Handshake strobes decode straight from the state register, so OUT offer
    // and IN request are mutually exclusive by construction.
    assign port_out_valid = (state_q == ST_PORT_OUT);
    assign port_in_ready  = (state_q == ST_PORT_IN);
    assign bus.ack        = (state_q == ST_RESP);
    assign bus.err        = err_q;
    assign bus.rdata      = rdata_q;

    // Protocol invariants of the responder, checked during simulation.
    a_port_excl: assert property (@(posedge clk) disable iff (reset)
        !(port_out_valid && port_in_ready));
    a_ack_gap: assert property (@(posedge clk) disable iff (reset)
        bus.ack |=> !bus.ack);

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios followed by random traffic.
// A driver issues requests and queues the expected response from a plain
// behavioural model; a monitor checks every ack against that queue; a port
// agent plays the external sink/source with a chosen handshake delay.
module tb_mem_io_responder;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int TO = 8;

    typedef struct {
        int          issue;
        int          lat;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [AW-1:0] port_addr;
    logic [DW-1:0] port_out_data;
    logic          port_out_valid;
    logic          port_out_ready;
    logic          port_in_ready;
    logic          port_in_valid;
    logic [DW-1:0] port_in_data;

    int checks;
    int errors;
    int cyc;

    exp_t exp_q[$];

    // Reference model state.
    logic [15:0] ref_mem [256];
    bit          ref_written [256];
    logic [7:0]  written_q[$];

    // Port agent configuration for the current request.
    int          ext_delay;
    logic [7:0]  ext_addr;
    logic [15:0] ext_data;
    int          act_cnt;

    mem_io_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    mem_io_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus_if),
        .port_addr      (port_addr),
        .port_out_data  (port_out_data),
        .port_out_valid (port_out_valid),
        .port_out_ready (port_out_ready),
        .port_in_ready  (port_in_ready),
        .port_in_valid  (port_in_valid),
        .port_in_data   (port_in_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Monitor: every ack must match the oldest expected response.
    logic prev_ack;
    initial begin
        exp_t e;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.ack) begin
                check("ack_back_to_back", prev_ack, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", bus_if.ack, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_latency", cyc - e.issue, e.lat);
                    check("err", bus_if.err, e.err);
                    check("rdata", bus_if.rdata, e.rdata);
                end
            end
            prev_ack = bus_if.ack;
        end
    end

    // Port agent: answers an OUT offer or IN request after ext_delay waiting cycles.
    initial begin
        port_out_ready = 1'b0;
        port_in_valid  = 1'b0;
        port_in_data   = '0;
        act_cnt        = 0;
        forever begin
            @(negedge clk);
            if (port_out_valid || port_in_ready) begin
                act_cnt++;
                check("port_valid_ready_excl", port_out_valid & port_in_ready, 1'b0);
                if (act_cnt > ext_delay) begin
                    if (port_out_valid) begin
                        port_out_ready = 1'b1;
                        check("port_addr_out", port_addr, ext_addr);
                        check("port_out_data", port_out_data, ext_data);
                    end else begin
                        port_in_valid = 1'b1;
                        port_in_data  = ext_data;
                        check("port_addr_in", port_addr, ext_addr);
                    end
                end else begin
                    port_out_ready = 1'b0;
                    port_in_valid  = 1'b0;
                    port_in_data   = 16'($urandom);
                end
            end else begin
                act_cnt        = 0;
                port_out_ready = 1'b0;
                port_in_valid  = 1'b0;
                port_in_data   = 16'($urandom);
            end
        end
    end

    // Issue one request and wait for its ack. b2b: req is still high from the
    // previous ack, so the request is taken one cycle later than a fresh one.
    // hold: leave req high after the ack for the next back-to-back request.
    task automatic do_req(input bit w, input bit p, input logic [7:0] a,
                          input logic [15:0] d, input int delay,
                          input bit b2b, input bit hold);
        exp_t e;
        int   n;
        if (!b2b) @(negedge clk);
        ext_delay = delay;
        ext_addr  = a;
        ext_data  = d;
        e.issue   = cyc + (b2b ? 1 : 0);
        if (!p) begin
            if (w) begin
                ref_mem[a] = d;
                if (!ref_written[a]) written_q.push_back(a);
                ref_written[a] = 1'b1;
                e.lat = 1; e.err = 1'b0; e.rdata = '0;
            end else begin
                e.lat = 2; e.err = 1'b0; e.rdata = ref_mem[a];
            end
        end else if (delay < TO) begin
            e.lat = delay + 2; e.err = 1'b0; e.rdata = w ? 16'h0 : d;
        end else begin
            e.lat = TO + 1; e.err = 1'b1; e.rdata = '0;
        end
        exp_q.push_back(e);
        bus_if.req       = 1'b1;
        bus_if.req_write = w;
        bus_if.req_port  = p;
        bus_if.req_addr  = a;
        bus_if.req_wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            // After acceptance the fields must be ignored: scramble them.
            if (!bus_if.ack && cyc > e.issue) begin
                bus_if.req_write = 1'($urandom);
                bus_if.req_port  = 1'($urandom);
                bus_if.req_addr  = 8'($urandom);
                bus_if.req_wdata = 16'($urandom);
            end
        end while (!bus_if.ack && n < TO + 10);
        if (!bus_if.ack) begin
            check("ack_wait_expired", bus_if.ack, 1'b1);
            finish_run();
        end
        if (!hold) bus_if.req = 1'b0;
    endtask

    initial begin
        bit          hold_prev;
        bit          hold;
        bit          w;
        bit          p;
        int          k;
        int          dly;
        logic [7:0]  a;

        checks    = 0;
        errors    = 0;
        ext_delay = 1000;
        ext_addr  = '0;
        ext_data  = '0;
        foreach (ref_written[i]) ref_written[i] = 1'b0;
        bus_if.req       = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_port  = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;

        // Reset values.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack", bus_if.ack, 1'b0);
        check("rst_err", bus_if.err, 1'b0);
        check("rst_rdata", bus_if.rdata, 16'h0);
        check("rst_port_out_valid", port_out_valid, 1'b0);
        check("rst_port_in_ready", port_in_ready, 1'b0);
        check("rst_port_addr", port_addr, 8'h0);
        check("rst_port_out_data", port_out_data, 16'h0);
        reset = 1'b0;

        // Store then load the same word.
        do_req(1'b1, 1'b0, 8'h12, 16'hBEEF, 0, 1'b0, 1'b0);
        do_req(1'b0, 1'b0, 8'h12, 16'h0000, 0, 1'b0, 1'b0);
        // Top and bottom of the address space.
        do_req(1'b1, 1'b0, 8'hFF, 16'h0F0F, 0, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 8'h00, 16'hF0F0, 0, 1'b0, 1'b0);
        do_req(1'b0, 1'b0, 8'hFF, 16'h0000, 0, 1'b0, 1'b0);
        do_req(1'b0, 1'b0, 8'h00, 16'h0000, 0, 1'b0, 1'b0);

        // OUT with the sink ready after 4 waiting cycles.
        do_req(1'b1, 1'b1, 8'h03, 16'h00A5, 4, 1'b0, 1'b0);
        // IN with the source answering after 2 cycles, and immediately.
        do_req(1'b0, 1'b1, 8'h07, 16'h1234, 2, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 8'h08, 16'h4321, 0, 1'b0, 1'b0);

        // Timeouts, and handshakes landing exactly on the expiry cycle.
        do_req(1'b0, 1'b1, 8'h09, 16'hDEAD, 1000, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 8'h09, 16'h5A5A, TO - 1, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 8'h0A, 16'h7777, TO, 1'b0, 1'b0);
        do_req(1'b1, 1'b1, 8'h0B, 16'h3C3C, TO - 1, 1'b0, 1'b0);
        do_req(1'b1, 1'b1, 8'h0C, 16'h6666, 1000, 1'b0, 1'b0);

        // Two stores with req held high throughout.
        do_req(1'b1, 1'b0, 8'h20, 16'h1111, 0, 1'b0, 1'b1);
        do_req(1'b1, 1'b0, 8'h21, 16'h2222, 0, 1'b1, 1'b0);
        do_req(1'b0, 1'b0, 8'h20, 16'h0000, 0, 1'b0, 1'b0);
        do_req(1'b0, 1'b0, 8'h21, 16'h0000, 0, 1'b0, 1'b0);

        // Reset while an OUT is waiting for its sink.
        @(negedge clk);
        ext_delay        = 1000;
        ext_addr         = 8'h05;
        ext_data         = 16'hCAFE;
        bus_if.req       = 1'b1;
        bus_if.req_write = 1'b1;
        bus_if.req_port  = 1'b1;
        bus_if.req_addr  = 8'h05;
        bus_if.req_wdata = 16'hCAFE;
        repeat (3) @(negedge clk);
        check("abort_valid_before", port_out_valid, 1'b1);
        reset      = 1'b1;
        bus_if.req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_valid", port_out_valid, 1'b0);
        check("abort_ack", bus_if.ack, 1'b0);
        check("abort_port_addr", port_addr, 8'h0);
        check("abort_port_out_data", port_out_data, 16'h0);
        repeat (3) @(negedge clk);
        do_req(1'b0, 1'b0, 8'h12, 16'h0000, 0, 1'b0, 1'b0);

        // Random traffic.
        hold_prev = 1'b0;
        for (int i = 0; i < 120; i++) begin
            k = $urandom_range(0, 3);
            if (k == 0 && written_q.size() == 0) k = 1;
            w   = (k == 1) || (k == 3);
            p   = (k >= 2);
            if (k == 0) a = written_q[$urandom_range(0, written_q.size() - 1)];
            else        a = 8'($urandom);
            dly  = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, TO + 1);
            hold = 1'($urandom);
            do_req(w, p, a, 16'($urandom), dly, hold_prev, hold);
            hold_prev = hold;
        end
        bus_if.req = 1'b0;

        repeat (4) @(negedge clk);
        check("pending_responses", exp_q.size(), 0);
        finish_run();
    end

endmodule
